// File: rtl/sifh_hist_engine.sv
// Two-pass photon timestamp histogram engine.
// A coarse pass locates the busiest coarse bin per pixel, a window pass turns
// that bin into a fine-window base (TL), and a fine pass histograms inside the
// window to produce a per-pixel fine peak timestamp and its count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// CLEAR   | zero one histogram bin per cycle, clear per-pixel peak regs
// COARSE  | accept samples, histogram on the top NB timestamp bits
// WINDOW  | one pixel per cycle: coarse peak bin -> fine window base TL
// CLEAR2  | same as CLEAR, TL values are kept
// FINE    | accept samples, histogram in-window samples at fine resolution
// OUTPUT  | present one pixel result per out_valid/out_ready handshake
module sifh_hist_engine #(
    parameter int  NP       = 12,
    parameter int  NB       = 4,
    parameter int  PIXELS   = 2,
    parameter int  DATA_NUM = 2,
    parameter int  ACQ_NUM  = 3,
    parameter int  CNT_W    = 4,
    localparam int PW       = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NP-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_pixel,
    output logic [NP-1:0]    out_peak,
    output logic [CNT_W-1:0] out_count,
    output logic             fine_pass
);

    localparam int NBINS = PIXELS << NB;
    localparam int AW    = PW + NB;
    localparam int DW    = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int QW    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam int CS    = NP - NB;
    localparam int FS    = NP - 2 * NB;

    localparam logic [NP:0]      WIN      = (NP + 1)'(1) << CS;
    localparam logic [NP:0]      WIN_M1   = WIN - (NP + 1)'(1);
    localparam logic [NP:0]      HALF     = WIN >> 1;
    localparam logic [NP:0]      TL_MAX   = ((NP + 1)'(1) << NP) - WIN;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [AW-1:0]    LAST_BIN = AW'(NBINS - 1);
    localparam logic [PW-1:0]    LAST_PIX = PW'(PIXELS - 1);
    localparam logic [DW-1:0]    LAST_D   = DW'(DATA_NUM - 1);
    localparam logic [QW-1:0]    LAST_A   = QW'(ACQ_NUM - 1);

    typedef enum logic [2:0] {
        S_CLEAR, S_COARSE, S_WINDOW, S_CLEAR2, S_FINE, S_OUTPUT
    } state_t;

    state_t state;

    logic [CNT_W-1:0] hist [NBINS];
    logic [CNT_W-1:0] mx   [PIXELS];
    logic [NB-1:0]    mb   [PIXELS];
    logic [NP-1:0]    tl   [PIXELS];

    logic [AW-1:0] idx;
    logic [DW-1:0] d_cnt;
    logic [PW-1:0] p_cnt;
    logic [QW-1:0] a_cnt;

    // Update stage: one registered hit, applied to the histogram next cycle.
    logic          p1_valid;
    logic [PW-1:0] p1_pix;
    logic [NB-1:0] p1_bin;

    logic             fire, last_smp, clearing, hit, in_win;
    logic [NP-1:0]    cur_tl;
    logic [NP:0]      lo, hi, din;
    logic [NB-1:0]    f_bin, bin_sel;
    logic [AW-1:0]    p1_addr;
    logic [CNT_W-1:0] rd_cnt, inc_cnt;
    logic [PW-1:0]    w_pix, o_sel;
    logic [NB-1:0]    w_cbin;
    logic [NP:0]      w_sh, w_tl, w_tl_c;
    logic [NP-1:0]    o_peak;
    logic [CNT_W-1:0] o_cnt;

    assign fire     = in_valid && in_ready;
    assign last_smp = (d_cnt == LAST_D) && (p_cnt == LAST_PIX) && (a_cnt == LAST_A);
    assign clearing = (state == S_CLEAR) || (state == S_CLEAR2);

    // Fine window test and fine bin for the current pixel's TL.
    assign cur_tl  = tl[p_cnt];
    assign lo      = {1'b0, cur_tl};
    assign hi      = lo + WIN_M1;
    assign din     = {1'b0, in_data};
    assign in_win  = (din >= lo) && (din <= hi);
    assign f_bin   = NB'((in_data - cur_tl) >> FS);
    assign bin_sel = (state == S_FINE) ? f_bin : in_data[NP-1:CS];
    assign hit     = !(&in_data) && ((state == S_FINE) ? in_win : 1'b1);

    // The write of one update lands at the same edge the next hit is
    // registered, so back-to-back hits on one bin read the fresh count.
    assign p1_addr = {p1_pix, p1_bin};
    assign rd_cnt  = hist[p1_addr];
    assign inc_cnt = (rd_cnt == CNT_MAX) ? rd_cnt : rd_cnt + CNT_W'(1);

    // Coarse peak bin -> fine window base, clamped to the timestamp range.
    assign w_pix  = idx[PW-1:0];
    assign w_cbin = (mx[w_pix] == '0) ? '0 : mb[w_pix];
    assign w_sh   = (NP + 1)'(w_cbin) << CS;
    assign w_tl   = (w_cbin == '0) ? '0 : w_sh - HALF;
    assign w_tl_c = (w_tl > TL_MAX) ? TL_MAX : w_tl;

    // Result fields for the pixel presented next.
    assign o_sel  = (state == S_OUTPUT) ? out_pixel + PW'(1) : '0;
    assign o_cnt  = mx[o_sel];
    assign o_peak = (o_cnt == '0) ? '1 : tl[o_sel] + (NP'(mb[o_sel]) << FS);

    // Histogram storage: bin clear during CLEAR/CLEAR2, otherwise hit updates.
    always_ff @(posedge clk) begin
        if (clearing) begin
            hist[idx] <= '0;
        end else if (p1_valid) begin
            hist[p1_addr] <= inc_cnt;
        end
    end

    // Sequencer, sample position tracking, peak tracking and result registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state     <= S_CLEAR;
            idx       <= '0;
            d_cnt     <= '0;
            p_cnt     <= '0;
            a_cnt     <= '0;
            p1_valid  <= 1'b0;
            p1_pix    <= '0;
            p1_bin    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_peak  <= '0;
            out_count <= '0;
            fine_pass <= 1'b0;
        end else begin
            p1_valid <= fire && hit;
            p1_pix   <= p_cnt;
            p1_bin   <= bin_sel;

            if (p1_valid && (inc_cnt > mx[p1_pix])) begin
                mx[p1_pix] <= inc_cnt;
                mb[p1_pix] <= p1_bin;
            end

            if (fire) begin
                if (d_cnt == LAST_D) begin
                    d_cnt <= '0;
                    if (p_cnt == LAST_PIX) begin
                        p_cnt <= '0;
                        a_cnt <= (a_cnt == LAST_A) ? '0 : a_cnt + QW'(1);
                    end else begin
                        p_cnt <= p_cnt + PW'(1);
                    end
                end else begin
                    d_cnt <= d_cnt + DW'(1);
                end
                if (last_smp) in_ready <= 1'b0;
            end

            case (state)
                S_CLEAR, S_CLEAR2: begin
                    for (int i = 0; i < PIXELS; i++) begin
                        mx[i] <= '0;
                        mb[i] <= '0;
                    end
                    if (idx == LAST_BIN) begin
                        idx      <= '0;
                        d_cnt    <= '0;
                        p_cnt    <= '0;
                        a_cnt    <= '0;
                        in_ready <= 1'b1;
                        state    <= (state == S_CLEAR) ? S_COARSE : S_FINE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                S_COARSE: begin
                    if (!in_ready && !p1_valid) state <= S_WINDOW;
                end
                S_WINDOW: begin
                    tl[w_pix] <= NP'(w_tl_c);
                    if (w_pix == LAST_PIX) begin
                        idx       <= '0;
                        fine_pass <= 1'b1;
                        state     <= S_CLEAR2;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                S_FINE: begin
                    if (!in_ready && !p1_valid) begin
                        out_valid <= 1'b1;
                        out_pixel <= '0;
                        out_peak  <= o_peak;
                        out_count <= o_cnt;
                        state     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (out_ready) begin
                        if (out_pixel == LAST_PIX) begin
                            out_valid <= 1'b0;
                            fine_pass <= 1'b0;
                            state     <= S_CLEAR;
                        end else begin
                            out_pixel <= o_sel;
                            out_peak  <= o_peak;
                            out_count <= o_cnt;
                        end
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_sifh_hist_engine.sv
// Scoreboard bench for sifh_hist_engine: a behavioural model predicts each
// pixel's fine peak/count from the sample sets, a monitor checks every
// presented result. A second instance with ACQ_NUM=8 exercises saturation.
module tb_sifh_hist_engine;

    localparam int NP       = 12;
    localparam int NB       = 4;
    localparam int PIXELS   = 2;
    localparam int DATA_NUM = 2;
    localparam int ACQ_NUM  = 3;
    localparam int CNT_W    = 4;
    localparam int NS       = DATA_NUM * ACQ_NUM;
    localparam int W        = 1 << (NP - NB);
    localparam int FW       = 1 << (NP - 2 * NB);
    localparam int NOPH     = (1 << NP) - 1;
    localparam int CMAX     = (1 << CNT_W) - 1;
    localparam int ACQ_SAT  = 8;

    logic              clk = 1'b0;
    logic              res, in_valid, in_ready, out_valid, out_ready, fine_pass;
    logic [NP-1:0]     in_data, out_peak;
    logic [0:0]        out_pixel;
    logic [CNT_W-1:0]  out_count;

    logic              res2, in_valid2, in_ready2, out_valid2, out_ready2, fine_pass2;
    logic [NP-1:0]     in_data2, out_peak2;
    logic [0:0]        out_pixel2;
    logic [CNT_W-1:0]  out_count2;

    typedef struct { int pix; int peak; int cnt; } exp_t;
    exp_t q[$];

    int n_vec = 0;
    int n_err = 0;
    int hold_left = 0;
    int ctr [PIXELS];
    bit sat_done = 0;

    always #5 clk = ~clk;

    sifh_hist_engine #(.NP(NP), .NB(NB), .PIXELS(PIXELS), .DATA_NUM(DATA_NUM),
                       .ACQ_NUM(ACQ_NUM), .CNT_W(CNT_W)) dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_peak(out_peak), .out_count(out_count),
        .fine_pass(fine_pass));

    sifh_hist_engine #(.NP(NP), .NB(NB), .PIXELS(PIXELS), .DATA_NUM(DATA_NUM),
                       .ACQ_NUM(ACQ_SAT), .CNT_W(CNT_W)) dut_sat (
        .clk(clk), .res(res2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_pixel(out_pixel2), .out_peak(out_peak2), .out_count(out_count2),
        .fine_pass(fine_pass2));

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired or no result expected", nm);
    endtask

    // Reference: count per bin with saturation, peak replaced only on a
    // strictly larger count, in arrival order.
    function automatic void hist_pick(input logic [NP-1:0] s [NS], input bit fine,
                                      input int tlv, output int pb, output int pm);
        int cnt [16];
        int v, b;
        foreach (cnt[i]) cnt[i] = 0;
        pb = 0;
        pm = 0;
        for (int k = 0; k < NS; k++) begin
            v = int'(s[k]);
            if (v == NOPH) continue;
            if (fine) begin
                if (v < tlv || v > tlv + W - 1) continue;
                b = (v - tlv) / FW;
            end else begin
                b = v / W;
            end
            if (cnt[b] < CMAX) cnt[b]++;
            if (cnt[b] > pm) begin
                pm = cnt[b];
                pb = b;
            end
        end
    endfunction

    function automatic logic [NP-1:0] jitter(input int c);
        int v;
        v = c + int'($urandom_range(0, 80)) - 40;
        if (v < 0) v = 0;
        if (v > NOPH - 1) v = NOPH - 1;
        return NP'(v);
    endfunction

    function automatic logic [NP-1:0] gen(input int kind, input int p, input int k, input bit fine);
        int r;
        case (kind)
            0: return (p == 0) ? 12'h345 : jitter(12'h8A0);
            1: return (p == 0) ? 12'h010 : 12'hFF0;
            2: return (p == 0) ? 12'hF40 : 12'hFFF;
            3: begin
                if (p == 0) return (fine && k >= 4) ? 12'h100 : 12'h345;
                return jitter(ctr[p]);
            end
            default: begin
                r = int'($urandom_range(0, 9));
                if (r == 0) return 12'hFFF;
                if (r == 1) return NP'($urandom_range(0, NOPH));
                return jitter(ctr[p]);
            end
        endcase
    endfunction

    task automatic send(input logic [NP-1:0] s);
        int t = 0;
        forever begin
            @(negedge clk);
            in_data  = s;
            in_valid = ($urandom_range(0, 3) != 0);
            if (in_valid && in_ready) break;
            t++;
            if (t > 2000) begin
                fail_now("send_timeout");
                break;
            end
        end
    endtask

    task automatic wait_ready_rise(input string nm);
        int n = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk);
            #1;
            if (in_ready) begin
                n = i;
                break;
            end
        end
        check(nm, n, PIXELS << NB);
    endtask

    task automatic run_frame(input int kind, input bit abort);
        logic [NP-1:0] cs [PIXELS][NS];
        logic [NP-1:0] fs [PIXELS][NS];
        logic [NP-1:0] tmp [NS];
        int cb, cm, fb, fm, tlv, pk;
        for (int p = 0; p < PIXELS; p++) ctr[p] = int'($urandom_range(0, NOPH));
        for (int p = 0; p < PIXELS; p++)
            for (int k = 0; k < NS; k++) begin
                cs[p][k] = gen(kind, p, k, 1'b0);
                fs[p][k] = gen(kind, p, k, 1'b1);
            end
        if (!abort) begin
            for (int p = 0; p < PIXELS; p++) begin
                for (int k = 0; k < NS; k++) tmp[k] = cs[p][k];
                hist_pick(tmp, 1'b0, 0, cb, cm);
                if (cm == 0) cb = 0;
                tlv = cb * W - W / 2;
                if (tlv < 0) tlv = 0;
                if (tlv > (1 << NP) - W) tlv = (1 << NP) - W;
                for (int k = 0; k < NS; k++) tmp[k] = fs[p][k];
                hist_pick(tmp, 1'b1, tlv, fb, fm);
                pk = (fm == 0) ? NOPH : tlv + fb * FW;
                q.push_back('{p, pk, fm});
            end
        end
        for (int a = 0; a < ACQ_NUM; a++)
            for (int p = 0; p < PIXELS; p++)
                for (int d = 0; d < DATA_NUM; d++) send(cs[p][a * DATA_NUM + d]);
        for (int a = 0; a < ACQ_NUM; a++)
            for (int p = 0; p < PIXELS; p++)
                for (int d = 0; d < DATA_NUM; d++) begin
                    if (abort && (a * PIXELS * DATA_NUM + p * DATA_NUM + d) == 5) return;
                    send(fs[p][a * DATA_NUM + d]);
                end
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_drop", int'(in_ready), 0);
    endtask

    // Monitor: drives out_ready, checks every cycle a result is presented.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_out");
                end else begin
                    check(out_ready ? "out_pixel" : "hold_pixel", int'(out_pixel), q[0].pix);
                    check(out_ready ? "out_peak" : "hold_peak", int'(out_peak), q[0].peak);
                    check(out_ready ? "out_count" : "hold_count", int'(out_count), q[0].cnt);
                    check("fine_pass_out", int'(fine_pass), 1);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Saturating instance: every sample hits one bin with no gaps.
    initial begin
        int t;
        res2 = 1'b1;
        in_valid2 = 1'b0;
        in_data2 = '0;
        out_ready2 = 1'b1;
        repeat (3) @(negedge clk);
        res2 = 1'b0;
        in_valid2 = 1'b1;
        in_data2 = 12'h345;
        t = 0;
        while (!out_valid2 && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid2) begin
            fail_now("sat_timeout");
        end else begin
            for (int p = 0; p < PIXELS; p++) begin
                check("sat_valid", int'(out_valid2), 1);
                check("sat_pixel", int'(out_pixel2), p);
                check("sat_count", int'(out_count2), CMAX);
                check("sat_peak", int'(out_peak2), 12'h340);
                @(negedge clk);
            end
        end
        in_valid2 = 1'b0;
        sat_done = 1'b1;
    end

    initial begin
        int t;
        res = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pixel", int'(out_pixel), 0);
        check("rst_out_peak", int'(out_peak), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_fine_pass", int'(fine_pass), 0);
        res = 1'b0;
        wait_ready_rise("ready_rise");

        hold_left = 5;
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b0);
        run_frame(3, 1'b0);

        run_frame(4, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        res = 1'b1;
        @(negedge clk);
        check("midfine_in_ready", int'(in_ready), 0);
        check("midfine_out_valid", int'(out_valid), 0);
        check("midfine_fine_pass", int'(fine_pass), 0);
        res = 1'b0;
        wait_ready_rise("ready_rise_again");

        for (int i = 0; i < 8; i++) run_frame(4, 1'b0);

        t = 0;
        while (q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("drain", q.size(), 0);
        t = 0;
        while (!sat_done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!sat_done) fail_now("sat_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
